sc_stream_decoder: RTL and testbench
====================================

# sc_stream_decoder

Receive side of the stochastic-computing datapath: consumes a serial SC bitstream one bit per accepted beat and counts ones over a fixed frame of STREAM_LENGTH beats. It then restores the binary scale by left-shifting the count by a per-frame exponent, and presents the result on a valid/ready output. It sits after the SC arithmetic lanes and converts normalized stochastic results back to DATA_WIDTH<<1 binary words.

## Interface
- DATA_WIDTH, 8: operand width of the upstream datapath.
- STREAM_LENGTH, 16: beats per frame; a power of two, at least 2.
- CNT_WIDTH, 5: ones-counter width, equal to log2(STREAM_LENGTH)+1.
- SHIFT_WIDTH, 4: exponent width.
- OUT_WIDTH, DATA_WIDTH<<1: result width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sc_clr  in  1  synchronous clear; abandons the current frame or held result.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accept.
- in_bit  in  1  stochastic bit.
- in_shift  in  SHIFT_WIDTH  exponent; sampled on the first accepted beat of a frame only.
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- out_data  out  OUT_WIDTH  decoded value.
- out_ovf  out  1  saturation flag, qualified by out_valid.

## Operation
- FSM states:
  - IDLE: no beats of the current frame accepted yet.
  - ACC: frame in progress.
  - HOLD: result registered, awaiting handshake.
- A beat is accepted when in_valid && in_ready. in_ready = (state != HOLD).
- IDLE transitions:
  - First accepted beat: latch in_shift, set ones_cnt = in_bit, set beat_cnt = 1, go to ACC.
  - When STREAM_LENGTH = 1 is not allowed, so IDLE always goes to ACC.
- ACC transitions:
  - Each accepted beat increments beat_cnt and adds in_bit to ones_cnt.
  - The beat with beat_cnt == STREAM_LENGTH-1 is the last beat. It computes the result from the final ones_cnt (including this bit), registers out_data/out_ovf, and goes to HOLD.
  - Cycles with in_valid low leave all counters unchanged.
- HOLD transitions:
  - out_valid = 1. out_data and out_ovf stay stable until out_valid && out_ready, then go to IDLE.
  - in_bit and in_shift are ignored.
- Arithmetic, unipolar:
  - value = ones_cnt << shift, computed at full width CNT_WIDTH+2^SHIFT_WIDTH-1.
  - If value > 2^OUT_WIDTH-1: out_data = all ones, out_ovf = 1. Otherwise out_data = value and out_ovf = 0.
- sc_clr:
  - Forces IDLE, zeroes the counters, deasserts out_valid, and clears out_data/out_ovf.
  - Takes priority over an accepted beat or an output handshake in the same cycle.
  - The beat presented in that cycle is dropped.
- Async reset:
  - Takes effect immediately, including mid-frame or in HOLD.
  - Reset values: state IDLE, beat_cnt 0, ones_cnt 0, out_valid 0, out_data 0, out_ovf 0. in_ready reads 1 once in IDLE.

## Timing
- Output latency: out_valid rises one cycle after the edge that accepts the last beat.
- Throughput: minimum frame period is STREAM_LENGTH+1 cycles (STREAM_LENGTH beats plus one handshake cycle with out_ready held high). No overlap between frames.
- Handshake: after the out_valid && out_ready edge, out_valid is low next cycle and in_ready is high the same next cycle.
- Combinational paths: none from out_ready to in_ready. in_ready depends on state only.

## Configuration
- SC_DEC_BIPOLAR_EN undefined: unipolar decoding as above; out_data is unsigned.
- SC_DEC_BIPOLAR_EN defined: bipolar decoding.
  - signed value = (2*ones_cnt - STREAM_LENGTH) << shift.
  - out_data is two's complement.
  - Saturation limits are -2^(OUT_WIDTH-1) and 2^(OUT_WIDTH-1)-1; either limit sets out_ovf.
  - FSM, handshake and timing are identical in both builds.

## Test plan
All scenarios use default parameters.
- Basic frame: 16 back-to-back beats, 8 ones, in_shift=4 -> out_data=0x0080, out_ovf=0, out_valid high the cycle after beat 16.
- Saturation boundary:
  - All ones, shift 11 -> 0x8000, out_ovf=0.
  - All ones, shift 12 -> 0xFFFF, out_ovf=1.
- Stalls on both sides:
  - in_valid low for 3 cycles between beats 5 and 6, 4 ones total, shift 0 -> out_data=4; gap cycles not counted.
  - out_ready low for 5 cycles -> out_data stable and in_ready=0; the handshake returns to IDLE.
- sc_clr mid-frame: assert after 7 beats, together with in_valid -> IDLE, that beat dropped. Next frame of 16 zeros, shift 0 -> out_data=0.
- Reset mid-frame and mid-HOLD: rst_n low -> out_valid/out_data/out_ovf read 0 with no clock edge. Next frame decodes correctly.
- Bipolar build:
  - 12 ones, shift 2 -> 0x0020.
  - 4 ones, shift 2 -> 0xFFE0.
  - All ones, shift 12 -> 0x7FFF with out_ovf=1.

Source files
------------

// File: rtl/sc_stream_decoder_if.sv
// ----------------------------------------------------------------------------
// sc_stream_decoder_if
// Handshake bundle of the SC stream decoder: the serial beat input
// (in_valid/in_ready/in_bit/in_shift) and the decoded result output
// (out_valid/out_ready/out_data/out_ovf).
// The "slave" modport is the decoder side; "master" is the side that
// supplies beats and consumes results.
// ----------------------------------------------------------------------------
interface sc_stream_decoder_if #(
    parameter int SHIFT_WIDTH = 4,
    parameter int OUT_WIDTH   = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_bit;
    logic [SHIFT_WIDTH-1:0] in_shift;
    logic                   out_valid;
    logic                   out_ready;
    logic [OUT_WIDTH-1:0]   out_data;
    logic                   out_ovf;

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_bit,
        input  in_shift,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_ovf
    );

    modport master (
        output in_valid,
        input  in_ready,
        output in_bit,
        output in_shift,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_ovf
    );
endinterface

// File: rtl/sc_stream_decoder.sv
// ----------------------------------------------------------------------------
// sc_stream_decoder
// Receive side of the stochastic-computing datapath. Counts ones over a frame
// of STREAM_LENGTH accepted beats, restores the binary scale by shifting the
// count left by the exponent captured on the first beat of the frame, and
// presents the saturated result on a valid/ready output.
//
// Build option: define SC_DEC_BIPOLAR_EN for bipolar decoding
// ((2*ones - STREAM_LENGTH) << shift, two's complement, signed saturation).
// Without it the decoder is unipolar (ones << shift, unsigned saturation).
// FSM, handshake and timing are the same in both builds.
// ----------------------------------------------------------------------------
module sc_stream_decoder #(
    parameter int DATA_WIDTH    = 8,
    parameter int STREAM_LENGTH = 16,
    parameter int CNT_WIDTH     = 5,
    parameter int SHIFT_WIDTH   = 4,
    parameter int OUT_WIDTH     = DATA_WIDTH << 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sc_clr,
    sc_stream_decoder_if.slave    bus
);

    // Width of the shifted count before saturation (unipolar / bipolar).
    localparam int UNI_W = CNT_WIDTH + (1 << SHIFT_WIDTH) - 1;
    localparam int BIP_W = CNT_WIDTH + 1 + (1 << SHIFT_WIDTH) - 1;

    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(STREAM_LENGTH - 1);
    localparam logic [CNT_WIDTH:0]   SL_EXT    = (CNT_WIDTH + 1)'(STREAM_LENGTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // ------------------------------------------------------------------------
    // Decode helpers: return {ovf, data}.
    // ------------------------------------------------------------------------
    function automatic logic [OUT_WIDTH:0] decode_unipolar(
        input logic [CNT_WIDTH-1:0]   ones,
        input logic [SHIFT_WIDTH-1:0] sh
    );
        logic [UNI_W-1:0] val;
        logic [OUT_WIDTH:0] res;
        val = {{(UNI_W-CNT_WIDTH){1'b0}}, ones} << sh;
        if (|val[UNI_W-1:OUT_WIDTH]) begin
            res = {1'b1, {OUT_WIDTH{1'b1}}};
        end else begin
            res = {1'b0, val[OUT_WIDTH-1:0]};
        end
        return res;
    endfunction

    function automatic logic [OUT_WIDTH:0] decode_bipolar(
        input logic [CNT_WIDTH-1:0]   ones,
        input logic [SHIFT_WIDTH-1:0] sh
    );
        logic [CNT_WIDTH:0] base;
        logic [BIP_W-1:0]   val;
        logic               sign;
        logic [OUT_WIDTH:0] res;
        // 2*ones - STREAM_LENGTH always fits CNT_WIDTH+1 signed bits.
        base = {ones, 1'b0} - SL_EXT;
        val  = {{(BIP_W-CNT_WIDTH-1){base[CNT_WIDTH]}}, base} << sh;
        sign = val[BIP_W-1];
        // In range only if every bit above the output sign bit copies the sign.
        if (val[BIP_W-1:OUT_WIDTH-1] == {(BIP_W-OUT_WIDTH+1){sign}}) begin
            res = {1'b0, val[OUT_WIDTH-1:0]};
        end else if (sign) begin
            res = {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            res = {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
        return res;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e                 state_q,     state_d;
    logic [CNT_WIDTH-1:0]   beat_cnt_q,  beat_cnt_d;
    logic [CNT_WIDTH-1:0]   ones_cnt_q,  ones_cnt_d;
    logic [SHIFT_WIDTH-1:0] shift_q,     shift_d;
    logic                   in_ready_q,  in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]   out_data_q,  out_data_d;
    logic                   out_ovf_q,   out_ovf_d;

    logic                   accept_s;
    logic [CNT_WIDTH-1:0]   bit_ext_s;
    logic [CNT_WIDTH-1:0]   ones_final_s;
    logic [OUT_WIDTH:0]     result_s;

    // Final ones count including the beat on the bus, and its decoded value.
    always_comb begin
        accept_s     = bus.in_valid & in_ready_q;
        bit_ext_s    = {{(CNT_WIDTH-1){1'b0}}, bus.in_bit};
        ones_final_s = ones_cnt_q + bit_ext_s;
`ifdef SC_DEC_BIPOLAR_EN
        result_s     = decode_bipolar(ones_final_s, shift_q);
`else
        result_s     = decode_unipolar(ones_final_s, shift_q);
`endif
    end

    // Next-state logic of the frame FSM; sc_clr wins over any handshake.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        shift_d     = shift_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;

        if (sc_clr) begin
            state_d     = ST_IDLE;
            beat_cnt_d  = {CNT_WIDTH{1'b0}};
            ones_cnt_d  = {CNT_WIDTH{1'b0}};
            shift_d     = {SHIFT_WIDTH{1'b0}};
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            out_data_d  = {OUT_WIDTH{1'b0}};
            out_ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        // First beat of a frame: the exponent is captured here only.
                        shift_d    = bus.in_shift;
                        ones_cnt_d = bit_ext_s;
                        beat_cnt_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        state_d    = ST_ACC;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
                ST_ACC: begin
                    if (accept_s) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            out_data_d  = result_s[OUT_WIDTH-1:0];
                            out_ovf_d   = result_s[OUT_WIDTH];
                            out_valid_d = 1'b1;
                            in_ready_d  = 1'b0;
                            beat_cnt_d  = {CNT_WIDTH{1'b0}};
                            ones_cnt_d  = {CNT_WIDTH{1'b0}};
                            state_d     = ST_HOLD;
                        end else begin
                            beat_cnt_d  = beat_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                            ones_cnt_d  = ones_final_s;
                            state_d     = ST_ACC;
                        end
                    end else begin
                        state_d = ST_ACC;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d     = ST_HOLD;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    beat_cnt_d  = {CNT_WIDTH{1'b0}};
                    ones_cnt_d  = {CNT_WIDTH{1'b0}};
                    shift_d     = {SHIFT_WIDTH{1'b0}};
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    out_data_d  = {OUT_WIDTH{1'b0}};
                    out_ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; async reset returns to an empty IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= {CNT_WIDTH{1'b0}};
            ones_cnt_q  <= {CNT_WIDTH{1'b0}};
            shift_q     <= {SHIFT_WIDTH{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= {OUT_WIDTH{1'b0}};
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            ones_cnt_q  <= ones_cnt_d;
            shift_q     <= shift_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// ----------------------------------------------------------------------------
// tb_sc_stream_decoder
// Self-checking bench: directed frames from the test plan plus randomized
// frames, compared against a behavioural decode of the frame's ones count.
// Honours SC_DEC_BIPOLAR_EN for the reference model and directed values.
// ----------------------------------------------------------------------------
module tb_sc_stream_decoder;

    logic clk;
    logic rst_n;
    logic sc_clr;

    int n_checks = 0;
    int n_errors = 0;

    sc_stream_decoder_if #(.SHIFT_WIDTH(4), .OUT_WIDTH(16)) bus ();

    sc_stream_decoder dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sc_clr (sc_clr),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: decode a frame with 'ones' ones and exponent 'sh'. Returns {ovf, data}.
    function automatic logic [16:0] ref_decode(input int ones, input int sh);
        longint v;
        logic [16:0] r;
`ifdef SC_DEC_BIPOLAR_EN
        v = longint'(2 * ones - 16) * (longint'(1) << sh);
        if (v > 32767)       r = {1'b1, 16'h7FFF};
        else if (v < -32768) r = {1'b1, 16'h8000};
        else                 r = {1'b0, 16'(v)};
`else
        v = longint'(ones) * (longint'(1) << sh);
        if (v > 65535) r = {1'b1, 16'hFFFF};
        else           r = {1'b0, 16'(v)};
`endif
        return r;
    endfunction

    task automatic idle_cycle();
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b1;
        bus.in_shift = 4'($urandom);
        @(posedge clk); #1;
    endtask

    task automatic drive_beat(input logic b, input logic [3:0] sh);
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        bus.in_shift = sh;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Send beats 0..n-1 of 'bits'; exponent only valid on beat 0.
    task automatic send_beats(input logic [15:0] bits, input int sh, input int n,
                              input int gap_pct, input int gap_at, input int gap_len);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) idle_cycle();
            end
            for (int g = 0; g < 3; g++) begin
                if (int'($urandom_range(99)) < gap_pct) idle_cycle();
            end
            drive_beat(bits[i], (i == 0) ? 4'(sh) : 4'($urandom));
        end
    endtask

    // Full frame plus result handshake after 'wait_n' stalled cycles.
    task automatic run_frame(input string tag, input logic [15:0] bits, input int sh,
                             input int gap_pct, input int gap_at, input int gap_len,
                             input int wait_n, input logic [16:0] exp);
        send_beats(bits, sh, 15, gap_pct, gap_at, gap_len);
        check({tag, ".pre_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".pre_ready"}, 32'(bus.in_ready), 32'd1);
        drive_beat(bits[15], 4'($urandom));
        check({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".data"},  32'(bus.out_data),  32'(exp[15:0]));
        check({tag, ".ovf"},   32'(bus.out_ovf),   32'(exp[16]));
        check({tag, ".in_rdy_hold"}, 32'(bus.in_ready), 32'd0);
        for (int w = 0; w < wait_n; w++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_bit    = 1'($urandom);
            bus.in_shift  = 4'($urandom);
            @(posedge clk); #1;
            check({tag, ".stall_data"},  32'(bus.out_data),  32'(exp[15:0]));
            check({tag, ".stall_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, ".stall_rdy"},   32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check({tag, ".post_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".post_ready"}, 32'(bus.in_ready),  32'd1);
    endtask

    typedef struct {
        logic [15:0] bits;
        int          sh;
        int          gap_at;
        int          wait_n;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [15:0] rbits;
        int          rsh;

        rst_n         = 1'b0;
        sc_clr        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.in_shift  = 4'd0;
        bus.out_ready = 1'b0;

        #12;
        check("rst.valid", 32'(bus.out_valid), 32'd0);
        check("rst.data",  32'(bus.out_data),  32'd0);
        check("rst.ovf",   32'(bus.out_ovf),   32'd0);
        check("rst.ready", 32'(bus.in_ready),  32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with hand-derived expected values.
`ifdef SC_DEC_BIPOLAR_EN
        vecs.push_back('{16'h5555,  4, -1, 0, {1'b0, 16'h0000}});
        vecs.push_back('{16'hFFFF, 11, -1, 0, {1'b1, 16'h7FFF}});
        vecs.push_back('{16'hFFFF, 12, -1, 0, {1'b1, 16'h7FFF}});
        vecs.push_back('{16'h1111,  0,  5, 5, {1'b0, 16'hFFF8}});
        vecs.push_back('{16'h7777,  2, -1, 1, {1'b0, 16'h0020}});
        vecs.push_back('{16'h1111,  2, -1, 0, {1'b0, 16'hFFE0}});
        vecs.push_back('{16'h0000, 15, -1, 2, {1'b1, 16'h8000}});
`else
        vecs.push_back('{16'h5555,  4, -1, 0, {1'b0, 16'h0080}});
        vecs.push_back('{16'hFFFF, 11, -1, 0, {1'b0, 16'h8000}});
        vecs.push_back('{16'hFFFF, 12, -1, 0, {1'b1, 16'hFFFF}});
        vecs.push_back('{16'h1111,  0,  5, 5, {1'b0, 16'h0004}});
        vecs.push_back('{16'h7777,  2, -1, 1, {1'b0, 16'h0030}});
        vecs.push_back('{16'h1111,  2, -1, 0, {1'b0, 16'h0010}});
        vecs.push_back('{16'h0000, 15, -1, 2, {1'b0, 16'h0000}});
`endif
        foreach (vecs[k]) begin
            run_frame($sformatf("dir%0d", k), vecs[k].bits, vecs[k].sh, 0,
                      vecs[k].gap_at, 3, vecs[k].wait_n, vecs[k].exp);
        end

        // sc_clr mid-frame, asserted together with a valid beat.
        send_beats(16'hFFFF, 3, 7, 0, -1, 0);
        sc_clr       = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        @(posedge clk); #1;
        sc_clr       = 1'b0;
        bus.in_valid = 1'b0;
        check("clr.valid", 32'(bus.out_valid), 32'd0);
        check("clr.ready", 32'(bus.in_ready),  32'd1);
        run_frame("clr_next", 16'h0000, 0, 0, -1, 0, 0, ref_decode(0, 0));

        // Async reset mid-frame: takes effect with no clock edge.
        send_beats(16'hFFFF, 2, 5, 0, -1, 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid.valid", 32'(bus.out_valid), 32'd0);
        check("rst_mid.ready", 32'(bus.in_ready),  32'd1);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame("rst_mid_next", 16'h00FF, 1, 0, -1, 0, 0, ref_decode(8, 1));

        // Async reset mid-HOLD.
        send_beats(16'hFFFF, 12, 16, 0, -1, 0);
        check("hold.valid", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_hold.valid", 32'(bus.out_valid), 32'd0);
        check("rst_hold.data",  32'(bus.out_data),  32'd0);
        check("rst_hold.ovf",   32'(bus.out_ovf),   32'd0);
        check("rst_hold.ready", 32'(bus.in_ready),  32'd1);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame("rst_hold_next", 16'hF0F0, 3, 0, -1, 0, 0, ref_decode(8, 3));

        // Randomized frames against the reference decode.
        for (int f = 0; f < 40; f++) begin
            rbits = 16'($urandom);
            if ($urandom_range(3) == 0) rbits = 16'hFFFF;
            if ($urandom_range(5) == 0) rbits = 16'h0000;
            rsh = int'($urandom_range(15));
            run_frame($sformatf("rnd%0d", f), rbits, rsh, 20, -1, 0,
                      int'($urandom_range(3)), ref_decode($countones(rbits), rsh));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
